// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, FSM states
// and the datapath mux select values.
package mc_ctrl_pkg;

    // Opcode field values
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    // funct value that turns an R-type into jr
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    // FSM states; FETCH must be 0 so state_o reads 0 out of reset
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_R_WB     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_I_WB     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_LW_WB    = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13,
        S_TRAP     = 4'd14
    } state_e;

    // ALU control ops
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_SLT   = 3'b010;
    localparam logic [2:0] ALU_RTYPE = 3'b100;

    // ALU B operand select
    localparam logic [1:0] ASB_RT     = 2'b00;
    localparam logic [1:0] ASB_FOUR   = 2'b01;
    localparam logic [1:0] ASB_IMM    = 2'b10;
    localparam logic [1:0] ASB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_RS     = 2'b11;

    // Destination register select
    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    // Write-back data select
    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b11;

    // Branch condition select
    localparam logic [1:0] BT_BEQ = 2'b00;
    localparam logic [1:0] BT_BNE = 2'b01;

    // States that issue a memory request and wait on mem_ready_i
    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// Moore output decode: maps the current state, the opcode latched in
// DECODE and mem_ready_i onto the datapath control signals.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3
) (
    input  logic [3:0]         state_i,
    input  logic [OP_W-1:0]    op_i,
    input  logic               mem_ready_i,
    output logic               PCWrite_o,
    output logic               PCWriteCond_o,
    output logic [1:0]         BranchType_o,
    output logic               IorD_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               IRWrite_o,
    output logic [1:0]         MemToReg_o,
    output logic [1:0]         RegDst_o,
    output logic               RegWrite_o,
    output logic               ALUSrcA_o,
    output logic [1:0]         ALUSrcB_o,
    output logic [ALUOP_W-1:0] ALU_op_o,
    output logic [1:0]         PCSource_o
);

    // Every control defaults low; each state raises only what it needs.
    always_comb begin
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        BranchType_o  = BT_BEQ;
        IorD_o        = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        IRWrite_o     = 1'b0;
        MemToReg_o    = M2R_ALUOUT;
        RegDst_o      = RD_RT;
        RegWrite_o    = 1'b0;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = ASB_RT;
        ALU_op_o      = ALUOP_W'(ALU_ADD);
        PCSource_o    = PCS_ALU;
        case (state_e'(state_i))
            S_FETCH: begin
                // PC+4 and IR load only commit on the cycle memory answers
                MemRead_o = 1'b1;
                ALUSrcB_o = ASB_FOUR;
                IRWrite_o = mem_ready_i;
                PCWrite_o = mem_ready_i;
            end
            S_DECODE: begin
                ALUSrcB_o = ASB_IMM_SH;
            end
            S_EXEC_R: begin
                ALUSrcA_o = 1'b1;
                ALU_op_o  = ALUOP_W'(ALU_RTYPE);
            end
            S_R_WB: begin
                RegDst_o   = RD_RD;
                RegWrite_o = 1'b1;
            end
            S_EXEC_I: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = ASB_IMM;
                ALU_op_o  = (op_i == OP_W'(OP_SLTI)) ? ALUOP_W'(ALU_SLT)
                                                      : ALUOP_W'(ALU_ADD);
            end
            S_I_WB: begin
                RegWrite_o = 1'b1;
            end
            S_MEM_ADDR: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = ASB_IMM;
            end
            S_MEM_RD: begin
                IorD_o    = 1'b1;
                MemRead_o = 1'b1;
            end
            S_LW_WB: begin
                MemToReg_o = M2R_MDR;
                RegWrite_o = 1'b1;
            end
            S_MEM_WR: begin
                IorD_o     = 1'b1;
                MemWrite_o = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA_o     = 1'b1;
                ALU_op_o      = ALUOP_W'(ALU_SUB);
                PCWriteCond_o = 1'b1;
                PCSource_o    = PCS_ALUOUT;
                BranchType_o  = (op_i == OP_W'(OP_BNE)) ? BT_BNE : BT_BEQ;
            end
            S_JUMP: begin
                PCWrite_o  = 1'b1;
                PCSource_o = PCS_JUMP;
            end
            S_JAL: begin
                PCWrite_o  = 1'b1;
                PCSource_o = PCS_JUMP;
                RegDst_o   = RD_RA;
                MemToReg_o = M2R_PC;
                RegWrite_o = 1'b1;
            end
            S_JR: begin
                PCWrite_o  = 1'b1;
                PCSource_o = PCS_RS;
            end
            default: ; // TRAP and unused encodings drive nothing
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control unit: state register, opcode latch, memory
// watchdog and sticky error flags. Output decode lives in mc_ctrl_outdec.
//
// Memory handshake: in FETCH/MEM_RD/MEM_WR the request (MemRead_o or
// MemWrite_o) and IorD_o are held every cycle until mem_ready_i is seen
// high at a rising edge; that edge completes the transfer and advances the
// state. mem_ready_i is ignored in every other state.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [OP_W-1:0]    instr_op_i,
    input  logic [OP_W-1:0]    funct_i,
    input  logic               mem_ready_i,
    output logic               PCWrite_o,
    output logic               PCWriteCond_o,
    output logic [1:0]         BranchType_o,
    output logic               IorD_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               IRWrite_o,
    output logic [1:0]         MemToReg_o,
    output logic [1:0]         RegDst_o,
    output logic               RegWrite_o,
    output logic               ALUSrcA_o,
    output logic [1:0]         ALUSrcB_o,
    output logic [ALUOP_W-1:0] ALU_op_o,
    output logic [1:0]         PCSource_o,
    output logic               illegal_o,
    output logic               mem_err_o,
    output logic [3:0]         state_o
);

    // A zero TIMEOUT still needs a 1-bit counter to keep widths legal.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q;
    logic [CNT_W-1:0]  wd_cnt_q;
    logic              illegal_q;
    logic              mem_err_q;
    logic              wd_expired;

    // Watchdog fires only while still waiting; a same-cycle ready wins.
    assign wd_expired = (TIMEOUT != 0) && is_mem_state(state_q) &&
                        !mem_ready_i && (wd_cnt_q == TO_VAL);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready_i)     state_d = S_DECODE;
                else if (wd_expired) state_d = S_TRAP;
            end
            S_DECODE: begin
                case (instr_op_i)
                    OP_W'(OP_R):    state_d = (funct_i == OP_W'(FUNCT_JR)) ? S_JR : S_EXEC_R;
                    OP_W'(OP_ADDI),
                    OP_W'(OP_SLTI): state_d = S_EXEC_I;
                    OP_W'(OP_LW),
                    OP_W'(OP_SW):   state_d = S_MEM_ADDR;
                    OP_W'(OP_BEQ),
                    OP_W'(OP_BNE):  state_d = S_BRANCH;
                    OP_W'(OP_J):    state_d = S_JUMP;
                    OP_W'(OP_JAL):  state_d = S_JAL;
                    default:        state_d = S_TRAP;
                endcase
            end
            S_EXEC_R:   state_d = S_R_WB;
            S_EXEC_I:   state_d = S_I_WB;
            S_MEM_ADDR: state_d = (op_q == OP_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready_i)     state_d = S_LW_WB;
                else if (wd_expired) state_d = S_TRAP;
            end
            S_MEM_WR: begin
                if (mem_ready_i)     state_d = S_FETCH;
                else if (wd_expired) state_d = S_TRAP;
            end
            S_R_WB, S_I_WB, S_LW_WB,
            S_BRANCH, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    // Opcode latch, watchdog counter and sticky error flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q      <= '0;
            wd_cnt_q  <= '0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            if (state_q == S_DECODE) op_q <= instr_op_i;
            // Any state change restarts the count for the next memory state
            if (state_d != state_q) begin
                wd_cnt_q <= '0;
            end else if (is_mem_state(state_q) && !mem_ready_i && (wd_cnt_q != TO_VAL)) begin
                wd_cnt_q <= wd_cnt_q + CNT_W'(1);
            end
            if (state_q == S_DECODE && state_d == S_TRAP) illegal_q <= 1'b1;
            if (wd_expired) mem_err_q <= 1'b1;
        end
    end

    // Output decode
    mc_ctrl_outdec #(
        .OP_W    (OP_W),
        .ALUOP_W (ALUOP_W)
    ) u_outdec (
        .state_i       (state_q),
        .op_i          (op_q),
        .mem_ready_i   (mem_ready_i),
        .PCWrite_o     (PCWrite_o),
        .PCWriteCond_o (PCWriteCond_o),
        .BranchType_o  (BranchType_o),
        .IorD_o        (IorD_o),
        .MemRead_o     (MemRead_o),
        .MemWrite_o    (MemWrite_o),
        .IRWrite_o     (IRWrite_o),
        .MemToReg_o    (MemToReg_o),
        .RegDst_o      (RegDst_o),
        .RegWrite_o    (RegWrite_o),
        .ALUSrcA_o     (ALUSrcA_o),
        .ALUSrcB_o     (ALUSrcB_o),
        .ALU_op_o      (ALU_op_o),
        .PCSource_o    (PCSource_o)
    );

    assign illegal_o = illegal_q;
    assign mem_err_o = mem_err_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (TIMEOUT=4). Each driven cycle pushes
// its hand-written expected control vector; a monitor pops and compares on
// the falling edge.
module tb_multicycle_ctrl;
    import mc_ctrl_pkg::*;

    localparam int W = 27;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_i = 1'b1;
    logic [5:0] instr_op_i = '0;
    logic [5:0] funct_i = '0;
    logic       mem_ready_i = 1'b0;

    logic       PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o;
    logic       IRWrite_o, RegWrite_o, ALUSrcA_o, illegal_o, mem_err_o;
    logic [1:0] BranchType_o, MemToReg_o, RegDst_o, ALUSrcB_o, PCSource_o;
    logic [2:0] ALU_op_o;
    logic [3:0] state_o;

    multicycle_ctrl #(.TIMEOUT(4), .OP_W(6), .ALUOP_W(3)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .instr_op_i    (instr_op_i),
        .funct_i       (funct_i),
        .mem_ready_i   (mem_ready_i),
        .PCWrite_o     (PCWrite_o),
        .PCWriteCond_o (PCWriteCond_o),
        .BranchType_o  (BranchType_o),
        .IorD_o        (IorD_o),
        .MemRead_o     (MemRead_o),
        .MemWrite_o    (MemWrite_o),
        .IRWrite_o     (IRWrite_o),
        .MemToReg_o    (MemToReg_o),
        .RegDst_o      (RegDst_o),
        .RegWrite_o    (RegWrite_o),
        .ALUSrcA_o     (ALUSrcA_o),
        .ALUSrcB_o     (ALUSrcB_o),
        .ALU_op_o      (ALU_op_o),
        .PCSource_o    (PCSource_o),
        .illegal_o     (illegal_o),
        .mem_err_o     (mem_err_o),
        .state_o       (state_o)
    );

    // Observed vector: state, controls, then {illegal, mem_err}
    logic [W-1:0] act;
    assign act = {state_o, PCWrite_o, PCWriteCond_o, BranchType_o, IorD_o,
                  MemRead_o, MemWrite_o, IRWrite_o, MemToReg_o, RegDst_o,
                  RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALU_op_o, PCSource_o,
                  illegal_o, mem_err_o};

    function automatic logic [W-1:0] cv(
        input logic [3:0] st, input logic pcw, input logic pcwc,
        input logic [1:0] bt, input logic iord, input logic mr,
        input logic mw, input logic irw, input logic [1:0] m2r,
        input logic [1:0] rd, input logic rw, input logic asa,
        input logic [1:0] asb, input logic [2:0] alu, input logic [1:0] pcs);
        return {st, pcw, pcwc, bt, iord, mr, mw, irw, m2r, rd, rw, asa, asb, alu, pcs, 2'b00};
    endfunction

    localparam logic [W-1:0] F_ILL = 27'd2;
    localparam logic [W-1:0] F_MEM = 27'd1;

    // Hand-written expected vectors per state
    logic [W-1:0] e_fetch_r, e_fetch_w, e_decode, e_exec_r, e_r_wb, e_exec_addi,
                  e_exec_slti, e_i_wb, e_mem_addr, e_mem_rd, e_lw_wb, e_mem_wr,
                  e_beq, e_bne, e_jump, e_jal, e_jr, e_trap;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           tests_run = 0;
    int           tests_failed = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] ev;
            string nm;
            ev = exp_q.pop_front();
            nm = name_q.pop_front();
            tests_run++;
            if (act !== ev) begin
                tests_failed++;
                $display("FAIL %s: got %b exp %b (t=%0t)", nm, act, ev, $time);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                        input logic rs, input logic chk, input logic [W-1:0] ev,
                        input string nm);
        @(posedge clk);
        #1;
        instr_op_i  = op;
        funct_i     = fn;
        mem_ready_i = rdy;
        rst_i       = rs;
        if (chk) begin
            exp_q.push_back(ev);
            name_q.push_back(nm);
        end
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                       input logic [W-1:0] ev, input string nm);
        step(op, fn, rdy, 1'b0, 1'b1, ev, nm);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running exp finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        //                 st          pcw pcwc bt    iord mr  mw  irw m2r    rd     rw  asa asb    alu     pcs
        e_fetch_r   = cv(S_FETCH,    1, 0, 2'b00, 0, 1, 0, 1, 2'b00, 2'b00, 0, 0, 2'b01, 3'b000, 2'b00);
        e_fetch_w   = cv(S_FETCH,    0, 0, 2'b00, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b01, 3'b000, 2'b00);
        e_decode    = cv(S_DECODE,   0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b11, 3'b000, 2'b00);
        e_exec_r    = cv(S_EXEC_R,   0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 3'b100, 2'b00);
        e_r_wb      = cv(S_R_WB,     0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 1, 0, 2'b00, 3'b000, 2'b00);
        e_exec_addi = cv(S_EXEC_I,   0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 3'b000, 2'b00);
        e_exec_slti = cv(S_EXEC_I,   0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 3'b010, 2'b00);
        e_i_wb      = cv(S_I_WB,     0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 3'b000, 2'b00);
        e_mem_addr  = cv(S_MEM_ADDR, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 3'b000, 2'b00);
        e_mem_rd    = cv(S_MEM_RD,   0, 0, 2'b00, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 2'b00);
        e_lw_wb     = cv(S_LW_WB,    0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, 1, 0, 2'b00, 3'b000, 2'b00);
        e_mem_wr    = cv(S_MEM_WR,   0, 0, 2'b00, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 2'b00);
        e_beq       = cv(S_BRANCH,   0, 1, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 3'b001, 2'b01);
        e_bne       = cv(S_BRANCH,   0, 1, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 3'b001, 2'b01);
        e_jump      = cv(S_JUMP,     1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 2'b10);
        e_jal       = cv(S_JAL,      1, 0, 2'b00, 0, 0, 0, 0, 2'b11, 2'b10, 1, 0, 2'b00, 3'b000, 2'b10);
        e_jr        = cv(S_JR,       1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 2'b11);
        e_trap      = cv(S_TRAP,     0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 2'b00);

        // reset held for two edges, unchecked (state unknown before reset)
        step(OP_ADDI, 6'd0, 1'b0, 1'b1, 1'b0, '0, "rst");
        step(OP_ADDI, 6'd0, 1'b0, 1'b1, 1'b0, '0, "rst");

        // addi, ready high: reset state is FETCH with MemRead=1, IorD=0
        run(OP_ADDI, 6'd0, 1'b1, e_fetch_r,   "addi_fetch");
        run(OP_ADDI, 6'd0, 1'b1, e_decode,    "addi_decode");
        run(6'd0,    6'd0, 1'b1, e_exec_addi, "addi_exec");   // op changed after DECODE
        run(6'd0,    6'd0, 1'b1, e_i_wb,      "addi_wb");

        // lw with 3 wait cycles in MEM_RD: 8 cycles total
        run(OP_LW, 6'd0, 1'b1, e_fetch_r,  "lw_fetch");
        run(OP_LW, 6'd0, 1'b0, e_decode,   "lw_decode");
        run(OP_SW, 6'd0, 1'b0, e_mem_addr, "lw_addr");        // latched op decides
        run(OP_LW, 6'd0, 1'b0, e_mem_rd,   "lw_wait1");
        run(OP_LW, 6'd0, 1'b0, e_mem_rd,   "lw_wait2");
        run(OP_LW, 6'd0, 1'b0, e_mem_rd,   "lw_wait3");
        run(OP_LW, 6'd0, 1'b1, e_mem_rd,   "lw_ready");
        run(OP_LW, 6'd0, 1'b1, e_lw_wb,    "lw_wb");

        // slti
        run(OP_SLTI, 6'd0, 1'b1, e_fetch_r,   "slti_fetch");
        run(OP_SLTI, 6'd0, 1'b1, e_decode,    "slti_decode");
        run(OP_ADDI, 6'd0, 1'b1, e_exec_slti, "slti_exec");
        run(OP_SLTI, 6'd0, 1'b1, e_i_wb,      "slti_wb");

        // R-type add
        run(OP_R, 6'b100000, 1'b1, e_fetch_r, "r_fetch");
        run(OP_R, 6'b100000, 1'b1, e_decode,  "r_decode");
        run(OP_R, 6'b100000, 1'b1, e_exec_r,  "r_exec");
        run(OP_R, 6'b100000, 1'b1, e_r_wb,    "r_wb");

        // sw: one fetch wait, then 4 MEM_WR waits and ready at expiry (ready wins)
        run(OP_SW, 6'd0, 1'b0, e_fetch_w,  "sw_fetch_wait");
        run(OP_SW, 6'd0, 1'b1, e_fetch_r,  "sw_fetch");
        run(OP_SW, 6'd0, 1'b1, e_decode,   "sw_decode");
        run(OP_SW, 6'd0, 1'b0, e_mem_addr, "sw_addr");
        for (int i = 0; i < 4; i++) run(OP_SW, 6'd0, 1'b0, e_mem_wr, "sw_wait");
        run(OP_SW, 6'd0, 1'b1, e_mem_wr,   "sw_ready_at_expiry");

        // beq, bne, jal, j
        run(OP_BEQ, 6'd0, 1'b1, e_fetch_r, "beq_fetch");
        run(OP_BEQ, 6'd0, 1'b1, e_decode,  "beq_decode");
        run(OP_BEQ, 6'd0, 1'b1, e_beq,     "beq_branch");
        run(OP_BNE, 6'd0, 1'b1, e_fetch_r, "bne_fetch");
        run(OP_BNE, 6'd0, 1'b1, e_decode,  "bne_decode");
        run(OP_BEQ, 6'd0, 1'b1, e_bne,     "bne_branch");
        run(OP_JAL, 6'd0, 1'b1, e_fetch_r, "jal_fetch");
        run(OP_JAL, 6'd0, 1'b1, e_decode,  "jal_decode");
        run(OP_JAL, 6'd0, 1'b1, e_jal,     "jal_exec");
        run(OP_J,   6'd0, 1'b1, e_fetch_r, "j_fetch");
        run(OP_J,   6'd0, 1'b1, e_decode,  "j_decode");
        run(OP_J,   6'd0, 1'b1, e_jump,    "j_exec");

        // jr
        run(OP_R, FUNCT_JR, 1'b1, e_fetch_r, "jr_fetch");
        run(OP_R, FUNCT_JR, 1'b1, e_decode,  "jr_decode");
        run(OP_R, FUNCT_JR, 1'b1, e_jr,      "jr_exec");

        // R-type aborted by reset during EXEC_R: FETCH next, no RegWrite
        run(OP_R, 6'b100000, 1'b1, e_fetch_r, "abort_fetch");
        run(OP_R, 6'b100000, 1'b1, e_decode,  "abort_decode");
        step(OP_R, 6'b100000, 1'b1, 1'b1, 1'b1, e_exec_r, "abort_exec_rst");
        run(OP_SW, 6'd0, 1'b1, e_fetch_r, "abort_refetch");

        // sw that never completes: TRAP after 4 waits plus the expiry cycle
        run(OP_SW, 6'd0, 1'b0, e_decode,   "to_decode");
        run(OP_SW, 6'd0, 1'b0, e_mem_addr, "to_addr");
        for (int i = 0; i < 5; i++) run(OP_SW, 6'd0, 1'b0, e_mem_wr, "to_wait");
        run(OP_SW, 6'd0, 1'b1, e_trap | F_MEM, "to_trap1");
        run(OP_SW, 6'd0, 1'b0, e_trap | F_MEM, "to_trap2");
        step(OP_SW, 6'd0, 1'b1, 1'b1, 1'b1, e_trap | F_MEM, "to_trap_rst");
        run(6'b111111, 6'd0, 1'b1, e_fetch_r, "post_to_fetch");

        // illegal opcode: TRAP from DECODE, no PCWrite after the fetch
        run(6'b111111, 6'd0, 1'b1, e_decode,       "ill_decode");
        run(OP_J,      6'd0, 1'b1, e_trap | F_ILL, "ill_trap1");
        run(OP_J,      6'd0, 1'b1, e_trap | F_ILL, "ill_trap2");
        step(OP_J, 6'd0, 1'b1, 1'b1, 1'b1, e_trap | F_ILL, "ill_trap_rst");
        run(OP_J, 6'd0, 1'b0, e_fetch_w, "post_ill_fetch");

        // drain the scoreboard, bounded
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: got %0d pending exp 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
